sync_fifo_lvl: RTL and testbench

//  Single-clock show-ahead FIFO with occupancy count, runtime almost-full/almost-empty thresholds,

---
 rtl/sync_fifo_lvl_pkg.sv | 29 ++
 rtl/sync_fifo_lvl_if.sv | 37 +++
 rtl/sync_fifo_lvl_ram.sv | 25 ++
 rtl/sync_fifo_lvl.sv | 104 ++++++++++
 tb/tb_sync_fifo_lvl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_lvl_pkg.sv
// Shared types and helpers for the single-clock level-reporting FIFO.
// Provides the default geometry, the pointer type and the occupancy helper.
package sync_fifo_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 4;

  // Wide enough for any practical ASIZE; callers narrow the result to ASIZE+1 bits.
  localparam int PTR_MAX_W = 17;

  typedef logic [ASIZE_DEF:0]   ptr_t;
  typedef logic [PTR_MAX_W-1:0] ptr_wide_t;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_status_t;

  // Occupancy is the modular distance between pointers of asize+1 bits.
  function automatic ptr_wide_t ptr_level(input ptr_wide_t wr, input ptr_wide_t rd,
                                          input int asize);
    ptr_wide_t mask;
    mask = (ptr_wide_t'(1) << (asize + 1)) - ptr_wide_t'(1);
    return (wr - rd) & mask;
  endfunction

endpackage

// File: rtl/sync_fifo_lvl_if.sv
// Bus bundle for sync_fifo_lvl: write side, show-ahead read side, thresholds and error flags.
// master drives requests and thresholds; slave is the FIFO.
interface sync_fifo_lvl_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) ();

  // Handshake: a write is taken on a rising clk edge when wr_en && !wr_full && !flush;
  // a read pops the head shown on rd_data when rd_en && !rd_empty && !flush. Requests
  // against a full/empty FIFO are dropped (and recorded in ovf/udf when enabled).
  logic             flush;
  logic             wr_en;
  logic [DSIZE-1:0] wr_data;
  logic             wr_full;
  logic             wr_afull;
  logic             rd_en;
  logic [DSIZE-1:0] rd_data;
  logic             rd_empty;
  logic             rd_aempty;
  logic [ASIZE:0]   level;
  logic [ASIZE:0]   afull_thr;
  logic [ASIZE:0]   aempty_thr;
  logic             err_clr;
  logic             ovf;
  logic             udf;

  modport master (
    output flush, wr_en, wr_data, rd_en, afull_thr, aempty_thr, err_clr,
    input  wr_full, wr_afull, rd_data, rd_empty, rd_aempty, level, ovf, udf
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, afull_thr, aempty_thr, err_clr,
    output wr_full, wr_afull, rd_data, rd_empty, rd_aempty, level, ovf, udf
  );

endinterface

// File: rtl/sync_fifo_lvl_ram.sv
// Storage array for sync_fifo_lvl: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module sync_fifo_ram #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [ASIZE-1:0] wr_addr,
  input  logic [DSIZE-1:0] wr_data,
  input  logic [ASIZE-1:0] rd_addr,
  output logic [DSIZE-1:0] rd_data
);

  logic [DSIZE-1:0] mem [2**ASIZE];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock show-ahead FIFO with occupancy level, runtime almost-full/empty thresholds and flush.
// Define SYNC_FIFO_ERR_FLAGS_EN to enable the sticky ovf/udf flags; otherwise they read as 0.
module sync_fifo_lvl
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  sync_fifo_lvl_if.slave  bus
);

  logic [ASIZE:0] wr_ptr;
  logic [ASIZE:0] rd_ptr;
  logic [ASIZE:0] level_i;
  logic           full;
  logic           empty;
  logic           wr_acc;
  logic           rd_acc;
  fifo_status_t   status;

  // MSB is the wrap bit: equal pointers mean empty, equal low bits with differing MSBs mean full.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ASIZE-1:0] == rd_ptr[ASIZE-1:0]) && (wr_ptr[ASIZE] != rd_ptr[ASIZE]);
  assign level_i = (ASIZE+1)'(ptr_level(ptr_wide_t'(wr_ptr), ptr_wide_t'(rd_ptr), ASIZE));

  // Acceptance looks only at the current state, so a full FIFO cannot take a write in the
  // same cycle it pops, and an empty FIFO cannot pop the entry being written.
  assign wr_acc = bus.wr_en && !full  && !bus.flush;
  assign rd_acc = bus.rd_en && !empty && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + (ASIZE+1)'(1);
      if (rd_acc) rd_ptr <= rd_ptr + (ASIZE+1)'(1);
    end
  end

  sync_fifo_ram #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ASIZE-1:0]),
    .wr_data (bus.wr_data),
    .rd_addr (rd_ptr[ASIZE-1:0]),
    .rd_data (bus.rd_data)
  );

  assign status.full   = full;
  assign status.empty  = empty;
  assign status.afull  = (level_i >= bus.afull_thr);
  assign status.aempty = (level_i <= bus.aempty_thr);

  assign bus.wr_full   = status.full;
  assign bus.rd_empty  = status.empty;
  assign bus.wr_afull  = status.afull;
  assign bus.rd_aempty = status.aempty;
  assign bus.level     = level_i;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;

  // A new error in the same cycle as err_clr stays visible; flush discards history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (bus.flush) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.wr_en && full)       ovf_q <= 1'b1;
      else if (bus.err_clr)        ovf_q <= 1'b0;
      if (bus.rd_en && empty)      udf_q <= 1'b1;
      else if (bus.err_clr)        udf_q <= 1'b0;
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;
`else
  logic err_clr_unused;
  assign err_clr_unused = bus.err_clr;
  assign bus.ovf        = 1'b0;
  assign bus.udf        = 1'b0;
`endif

  a_not_full_and_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(full && empty));

  a_level_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    level_i <= (ASIZE+1)'(2**ASIZE));

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed bench for sync_fifo_lvl: a vector table for single-cycle behaviour plus
// hand-written sequences for fill/drain, wrap, full/empty corners, flush and async reset.
module tb_sync_fifo_lvl;
  import sync_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam logic EF = 1'b1;
`else
  localparam logic EF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_lvl_if #(.DSIZE(DW), .ASIZE(AW)) bus ();

  sync_fifo_lvl #(.DSIZE(DW), .ASIZE(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          flush, wr, rd, clr;
    logic [DW-1:0] wdata;
    logic [AW:0]   afthr, aethr;
    logic [AW:0]   e_level;
    logic          e_full, e_empty, e_afull, e_aempty;
    logic          chk_data;
    logic [DW-1:0] e_data;
    logic          e_ovf, e_udf;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mkv(input logic f, w, r, c, input logic [DW-1:0] d,
                               input logic [AW:0] aft, aet, lvl,
                               input logic fu, em, af, ae, cd, input logic [DW-1:0] ed,
                               input logic ov, ud);
    vec_t v;
    v.flush = f; v.wr = w; v.rd = r; v.clr = c; v.wdata = d;
    v.afthr = aft; v.aethr = aet; v.e_level = lvl;
    v.e_full = fu; v.e_empty = em; v.e_afull = af; v.e_aempty = ae;
    v.chk_data = cd; v.e_data = ed; v.e_ovf = ov; v.e_udf = ud;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic w, input logic [DW-1:0] d,
                       input logic r, input logic c);
    bus.flush   = f;
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    bus.err_clr = c;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input int lvl, input logic fu, input logic em,
                           input logic af, input logic ae);
    chk($sformatf("%s level", tag), 32'(bus.level), 32'(lvl));
    chk($sformatf("%s wr_full", tag), 32'(bus.wr_full), 32'(fu));
    chk($sformatf("%s rd_empty", tag), 32'(bus.rd_empty), 32'(em));
    chk($sformatf("%s wr_afull", tag), 32'(bus.wr_afull), 32'(af));
    chk($sformatf("%s rd_aempty", tag), 32'(bus.rd_aempty), 32'(ae));
  endtask

  // ---------------- test ----------------
  initial begin
    logic [DW-1:0] d;

    idle();
    bus.afull_thr  = 5'd12;
    bus.aempty_thr = 5'd3;

    repeat (2) tick();
    chk_flags("reset", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("reset ovf", 32'(bus.ovf), 32'd0);
    chk("reset udf", 32'(bus.udf), 32'd0);
    rst_n = 1'b1;
    tick();

    // flush wr rd clr data afthr aethr | level full empty afull aempty chkd data ovf udf
    vecs[0]  = mkv(0,1,0,0,8'hA5, 12,3, 1, 0,0,0,1, 1,8'hA5, 0,0);
    vecs[1]  = mkv(0,1,0,0,8'h5A, 12,3, 2, 0,0,0,1, 1,8'hA5, 0,0);
    vecs[2]  = mkv(0,0,1,0,8'h00, 12,3, 1, 0,0,0,1, 1,8'h5A, 0,0);
    vecs[3]  = mkv(0,1,1,0,8'h33, 12,3, 1, 0,0,0,1, 1,8'h33, 0,0);
    vecs[4]  = mkv(0,0,1,0,8'h00, 12,3, 0, 0,1,0,1, 0,8'h00, 0,0);
    vecs[5]  = mkv(0,0,1,0,8'h00, 12,3, 0, 0,1,0,1, 0,8'h00, 0,EF);
    vecs[6]  = mkv(0,0,0,1,8'h00, 12,3, 0, 0,1,0,1, 0,8'h00, 0,0);
    vecs[7]  = mkv(0,1,1,0,8'h77, 12,3, 1, 0,0,0,1, 1,8'h77, 0,EF);
    vecs[8]  = mkv(0,0,0,0,8'h00, 12,0, 1, 0,0,0,0, 1,8'h77, 0,EF);
    vecs[9]  = mkv(0,0,0,0,8'h00,  1,3, 1, 0,0,1,1, 1,8'h77, 0,EF);
    vecs[10] = mkv(1,1,0,0,8'h99, 12,3, 0, 0,1,0,1, 0,8'h00, 0,0);
    vecs[11] = mkv(0,0,1,1,8'h00, 12,3, 0, 0,1,0,1, 0,8'h00, 0,EF);
    vecs[12] = mkv(1,0,0,0,8'h00, 12,3, 0, 0,1,0,1, 0,8'h00, 0,0);
    vecs[13] = mkv(0,1,0,0,8'hC3,  0,0, 1, 0,0,1,0, 1,8'hC3, 0,0);
    vecs[14] = mkv(1,0,0,0,8'h00, 12,3, 0, 0,1,0,1, 0,8'h00, 0,0);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].flush, vecs[i].wr, vecs[i].wdata, vecs[i].rd, vecs[i].clr);
      bus.afull_thr  = vecs[i].afthr;
      bus.aempty_thr = vecs[i].aethr;
      tick();
      chk_flags($sformatf("vec%0d", i), int'(vecs[i].e_level), vecs[i].e_full,
                vecs[i].e_empty, vecs[i].e_afull, vecs[i].e_aempty);
      chk($sformatf("vec%0d ovf", i), 32'(bus.ovf), 32'(vecs[i].e_ovf));
      chk($sformatf("vec%0d udf", i), 32'(bus.udf), 32'(vecs[i].e_udf));
      if (vecs[i].chk_data) chk($sformatf("vec%0d rd_data", i), 32'(bus.rd_data), 32'(vecs[i].e_data));
    end
    idle();

    // Fill 0x01..0x10: afull rises at 12, aempty falls at 4, full at 16.
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, 1'b1, DW'(i), 1'b0, 1'b0);
      tick();
      chk_flags($sformatf("fill%0d", i), i, (i == DEPTH), 1'b0, (i >= 12), (i <= 3));
      chk($sformatf("fill%0d head", i), 32'(bus.rd_data), 32'h01);
    end
    drive(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    chk("wr@full level", 32'(bus.level), 32'd16);
    chk("wr@full ovf", 32'(bus.ovf), 32'(EF));
    chk("wr@full head", 32'(bus.rd_data), 32'h01);

    // Drain in order, then read once more from empty.
    for (int i = 1; i <= DEPTH; i++) begin
      chk($sformatf("drain%0d rd_data", i), 32'(bus.rd_data), 32'(i));
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
      tick();
      chk($sformatf("drain%0d level", i), 32'(bus.level), 32'(DEPTH - i));
      chk($sformatf("drain%0d rd_empty", i), 32'(bus.rd_empty), 32'(i == DEPTH));
    end
    tick();
    chk("rd@empty udf", 32'(bus.udf), 32'(EF));
    chk("rd@empty level", 32'(bus.level), 32'd0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    tick();
    chk("err_clr ovf", 32'(bus.ovf), 32'd0);
    chk("err_clr udf", 32'(bus.udf), 32'd0);

    // Steady level 5 with simultaneous traffic across several pointer wraps.
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      d = DW'(8'h20 + i);
      drive(1'b0, 1'b1, d, 1'b0, 1'b0);
      exp_q.push_back(d);
      tick();
    end
    chk("steady start level", 32'(bus.level), 32'd5);
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("steady%0d head", k), 32'(bus.rd_data), 32'(exp_q[0]));
      d = DW'(8'h40 + k);
      drive(1'b0, 1'b1, d, 1'b1, 1'b0);
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(d);
      chk($sformatf("steady%0d level", k), 32'(bus.level), 32'd5);
    end
    chk("steady end head", 32'(bus.rd_data), 32'(exp_q[0]));

    // Full with simultaneous wr+rd, then flush at level 9 with a write pending.
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    tick();
    chk("flush0 level", 32'(bus.level), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
      tick();
    end
    chk("full2 wr_full", 32'(bus.wr_full), 32'd1);
    drive(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
    tick();
    chk("full2 ovf", 32'(bus.ovf), 32'(EF));
    drive(1'b0, 1'b1, 8'hDD, 1'b1, 1'b0);
    tick();
    chk_flags("full wr+rd", 15, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("full wr+rd head", 32'(bus.rd_data), 32'h81);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    chk("lvl9 level", 32'(bus.level), 32'd9);
    chk("lvl9 head", 32'(bus.rd_data), 32'h87);
    drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    tick();
    chk_flags("flush9", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("flush9 ovf", 32'(bus.ovf), 32'd0);
    chk("flush9 udf", 32'(bus.udf), 32'd0);

    // Asynchronous reset in the middle of a fill, between clock edges.
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
      tick();
    end
    chk("prerst level", 32'(bus.level), 32'd3);
    chk("prerst udf", 32'(bus.udf), 32'(EF));
    #2;
    rst_n = 1'b0;
    #1;
    chk_flags("async rst", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("async rst udf", 32'(bus.udf), 32'd0);
    chk("async rst ovf", 32'(bus.ovf), 32'd0);
    tick();
    chk("rst held level", 32'(bus.level), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    tick();
    idle();
    chk("postrst level", 32'(bus.level), 32'd1);
    chk("postrst head", 32'(bus.rd_data), 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
